// File: rtl/ip_tx_upper_arbiter_if.sv
// AXI-Stream beat bundle (64-bit data, 56-bit IP header user field) shared by the
// arbiter's two source ports and its single downstream port.
interface ip_tx_upper_arbiter_if;
  logic [63:0] data;
  logic [55:0] user;
  logic [7:0]  keep;
  logic        last;
  logic        valid;
  logic        ready;

  modport master (output data, user, keep, last, valid, input ready);
  modport slave  (input data, user, keep, last, valid, output ready);
endinterface

// File: rtl/ip_tx_upper_arbiter.sv
// Packet-level arbiter of UDP (port 0) and ICMP (port 1) onto the IP TX upper AXIS input.
// Round-robin by default; define ARB_STRICT_PRIO_EN for fixed ICMP-wins-tie priority.
module ip_tx_upper_arbiter #(
  parameter int P_GAP_CYCLES = 2,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  ip_tx_upper_arbiter_if.slave         s0_axis,
  ip_tx_upper_arbiter_if.slave         s1_axis,
  ip_tx_upper_arbiter_if.master        m_axis,
  output logic [1:0]                   o_grant,
  output logic                         o_busy,
  output logic [P_CNT_WIDTH-1:0]       o_pkt_cnt0,
  output logic [P_CNT_WIDTH-1:0]       o_pkt_cnt1,
  output logic                         o_gap_err
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_grant, w_grant_nxt;
  logic [1:0]  r_ready, w_ready_nxt;
  logic [3:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic        r_in_gap;

  logic        w_sel;
  logic        w_valid_g, w_last_g, w_acc, w_hole, w_pkt_done;
  logic [63:0] w_data_g;
  logic [55:0] w_user_g;
  logic [7:0]  w_keep_g;

  assign w_valid_g  = r_grant[1] ? s1_axis.valid : s0_axis.valid;
  assign w_last_g   = r_grant[1] ? s1_axis.last  : s0_axis.last;
  assign w_data_g   = r_grant[1] ? s1_axis.data  : s0_axis.data;
  assign w_user_g   = r_grant[1] ? s1_axis.user  : s0_axis.user;
  assign w_keep_g   = r_grant[1] ? s1_axis.keep  : s0_axis.keep;

  // Ready is only ever raised for the granted port, so it doubles as "in XFER, granted".
  assign w_acc      = (|r_ready) && w_valid_g;
  assign w_hole     = (|r_ready) && !w_valid_g;
  assign w_pkt_done = w_acc && w_last_g;

  assign s0_axis.ready = r_ready[0];
  assign s1_axis.ready = r_ready[1];
  assign o_grant       = r_grant;
  assign o_busy        = (r_state != S_IDLE);

`ifdef ARB_STRICT_PRIO_EN
  assign w_sel = s1_axis.valid;
`else
  logic r_last_port;

  // Pointer holds the last granted port; reset to 1 so port 0 wins the first tie.
  assign w_sel = (s0_axis.valid && s1_axis.valid) ? ~r_last_port : s1_axis.valid;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_last_port <= 1'b1;
    else if (w_pkt_done)
      r_last_port <= r_grant[1];
  end
`endif

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path through the case infers a latch.
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ready_nxt   = 2'b00;
    w_gap_cnt_nxt = r_gap_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (m_axis.ready && (s0_axis.valid || s1_axis.valid)) begin
          w_grant_nxt = w_sel ? 2'b10 : 2'b01;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (w_pkt_done) begin
          w_grant_nxt   = 2'b00;
          w_gap_cnt_nxt = 4'd0;
          w_state_nxt   = S_GAP;
        end else begin
          w_ready_nxt = r_grant;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 4'(P_GAP_CYCLES - 1))
          w_state_nxt = S_IDLE;
        else
          w_gap_cnt_nxt = r_gap_cnt + 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_grant    <= 2'b00;
      r_ready    <= 2'b00;
      r_gap_cnt  <= 4'd0;
      r_in_gap   <= 1'b0;
      o_gap_err  <= 1'b0;
      o_pkt_cnt0 <= '0;
      o_pkt_cnt1 <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ready   <= w_ready_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_in_gap  <= w_hole;
      o_gap_err <= w_hole && !r_in_gap;
      if (w_pkt_done) begin
        if (r_grant[1])
          o_pkt_cnt1 <= o_pkt_cnt1 + P_CNT_WIDTH'(1);
        else
          o_pkt_cnt0 <= o_pkt_cnt0 + P_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_axis.valid <= 1'b0;
      m_axis.data  <= '0;
      m_axis.user  <= '0;
      m_axis.keep  <= '0;
      m_axis.last  <= 1'b0;
    end else begin
      m_axis.valid <= w_acc;
      if (w_acc) begin
        m_axis.data <= w_data_g;
        m_axis.user <= w_user_g;
        m_axis.keep <= w_keep_g;
        m_axis.last <= w_last_g;
      end
    end
  end

endmodule
